rf_fwd_stage: RTL and testbench
===============================

// Module: rf_fwd_stage
// PURPOSE
// - RF/FWD stage of the dual-issue SPU pipeline: a 128 x 128-bit register file with even and odd write ports.
// - Resolves all source operands for the even and odd instruction slots.
// - Operand priority: even/odd pipe forwarding staging registers, then same-cycle writeback, then the array.
// - Registers operands plus control into the ID/EX latch that feeds EvenPipe and OddPipe.
// PARAMETERS
// - FW_STAGES  7    staging entries per pipe visible for forwarding (index 0 = youngest)
// - NREGS      128  register file depth; address width is 7
// PORTS
// - clk                     in   1      clock
// - reset                   in   1      sync, active-high
// - stall                   in   1      hold ID/EX latch; no new operands captured
// - flush                   in   1      branch_taken from OddPipe; kill both slots
// - ev_op / od_op           in   11     decoded opcode per slot
// - ev_format / od_format   in   3      instr format
// - ev_unit / od_unit       in   2      execution unit select
// - ev_imm / od_imm         in   18     immediate
// - ev_rt_addr / od_rt_addr in   7      destination reg
// - ev_reg_write / od_reg_write in 1    slot writes RF
// - ev_ra/rb/rc_addr        in   7 ea   even sources (rc = 3rd operand)
// - od_ra/rb/rt_addr reads  -           odd sources ra, rb; store data read from od_rt_addr
// - od_ra_addr / od_rb_addr in   7      odd sources
// - pc_in                   in   8      PC of the issue pair
// - fw_ev_data / fw_od_data in   FW_STAGES*128  flattened staging values, entry i at [i*128 +: 128]
// - fw_ev_addr / fw_od_addr in   FW_STAGES*7    staging destination addresses
// - fw_ev_wr / fw_od_wr     in   FW_STAGES      staging entry valid write
// - wb_ev_data / wb_od_data in   128    writeback values
// - wb_ev_addr / wb_od_addr in   7      writeback addresses
// - wb_ev_we / wb_od_we     in   1      writeback enables
// - ev_x_op, ev_x_format, ev_x_unit, ev_x_imm, ev_x_rt_addr, ev_x_reg_write   out   as inputs   registered even control
// - od_x_op, od_x_format, od_x_unit, od_x_imm, od_x_rt_addr, od_x_reg_write   out   as inputs   registered odd control
// - ev_x_ra, ev_x_rb, ev_x_rc   out   128   even operands
// - od_x_ra, od_x_rb, od_x_rt_st   out   128   odd operands
// - x_pc                    out   8      registered PC
// BEHAVIOUR
// - Latency: sources sampled at posedge N; resolved operands visible on the ID/EX outputs after posedge N.
// - Operand resolution, per read port, first match wins:
//   1. lowest staging index i with fw_*_wr[i] and a matching address; at equal i, odd beats even.
//   2. wb_od (we and addr match).
//   3. wb_ev (we and addr match).
//   4. array[addr].
// - RF write at posedge: wb_ev, then wb_od.
//   - Same address on both ports stores wb_od_data, because the odd slot is later in program order.
// - stall=1: ID/EX outputs hold; RF writes still occur; operands are re-resolved when stall drops.
// - flush=1:
//   - At the next posedge, ev_x_reg_write and od_x_reg_write = 0 and ev_x_op/od_x_op = 0 (nop bubble).
//   - Operand values are don't-care.
//   - flush has priority over stall.
// - reset=1: every ID/EX output = 0 (reg_write 0, op 0, operands 0, x_pc 0). reset has priority over flush and stall.
// - Reset mid-operation: in-flight ID/EX contents are discarded; RF writes presented in the reset cycle are ignored.
// - Address 0 is an ordinary register; there is no hardwired zero.
// - A staging entry with fw_*_wr=0 never forwards, even on an address match.
// CONFIGURATION
// - RF_RESET_CLEAR_EN defined: reset also clears all NREGS array entries to 0 (sequential clear in the reset cycle).
// - RF_RESET_CLEAR_EN undefined: array contents are retained across reset; only the ID/EX latch is reset.
// TESTING
// - WB then read: wb_ev writes R5=128'hA5.., next cycle ev_ra_addr=5 -> ev_x_ra=128'hA5.. one clk later.
// - Same-cycle bypass: wb_od R7=128'h1234 while od_rb_addr=7 -> od_x_rb=128'h1234, with no stale array value.
// - Forward priority, all targeting R9:
//   - stimulus: fw_od[2]=X, fw_ev[4]=Y, wb_ev=Z, array=W.
//   - response: X. After dropping fw_od_wr[2] -> Y.
// - Equal-index tie: fw_ev[1] and fw_od[1] both R3 -> od value. Dual WB to R3 (E, O) -> later read returns O.
// - Stall 3 cycles, then flush, with both slots reg_write=1 -> outputs frozen 3 cycles, then x_reg_write=0 and op=0.
// - Reset mid-stream after R2=5 was written:
//   - all outputs go 0.
//   - read R2: returns 5 without RF_RESET_CLEAR_EN, 0 with it.

Source files
------------

// File: rtl/rf_fwd_stage.sv
// RF/FWD stage: 128x128 register file, operand forwarding, ID/EX latch.
// Define RF_RESET_CLEAR_EN to also zero the array during reset.
module rf_fwd_stage #(
  parameter int FW_STAGES = 7,
  parameter int NREGS     = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [10:0]                ev_op,
  input  logic [10:0]                od_op,
  input  logic [2:0]                 ev_format,
  input  logic [2:0]                 od_format,
  input  logic [1:0]                 ev_unit,
  input  logic [1:0]                 od_unit,
  input  logic [17:0]                ev_imm,
  input  logic [17:0]                od_imm,
  input  logic [6:0]                 ev_rt_addr,
  input  logic [6:0]                 od_rt_addr,
  input  logic                       ev_reg_write,
  input  logic                       od_reg_write,
  input  logic [6:0]                 ev_ra_addr,
  input  logic [6:0]                 ev_rb_addr,
  input  logic [6:0]                 ev_rc_addr,
  input  logic [6:0]                 od_ra_addr,
  input  logic [6:0]                 od_rb_addr,
  input  logic [7:0]                 pc_in,
  input  logic [FW_STAGES*128-1:0]   fw_ev_data,
  input  logic [FW_STAGES*128-1:0]   fw_od_data,
  input  logic [FW_STAGES*7-1:0]     fw_ev_addr,
  input  logic [FW_STAGES*7-1:0]     fw_od_addr,
  input  logic [FW_STAGES-1:0]       fw_ev_wr,
  input  logic [FW_STAGES-1:0]       fw_od_wr,
  input  logic [127:0]               wb_ev_data,
  input  logic [127:0]               wb_od_data,
  input  logic [6:0]                 wb_ev_addr,
  input  logic [6:0]                 wb_od_addr,
  input  logic                       wb_ev_we,
  input  logic                       wb_od_we,
  output logic [10:0]                ev_x_op,
  output logic [2:0]                 ev_x_format,
  output logic [1:0]                 ev_x_unit,
  output logic [17:0]                ev_x_imm,
  output logic [6:0]                 ev_x_rt_addr,
  output logic                       ev_x_reg_write,
  output logic [10:0]                od_x_op,
  output logic [2:0]                 od_x_format,
  output logic [1:0]                 od_x_unit,
  output logic [17:0]                od_x_imm,
  output logic [6:0]                 od_x_rt_addr,
  output logic                       od_x_reg_write,
  output logic [127:0]               ev_x_ra,
  output logic [127:0]               ev_x_rb,
  output logic [127:0]               ev_x_rc,
  output logic [127:0]               od_x_ra,
  output logic [127:0]               od_x_rb,
  output logic [127:0]               od_x_rt_st,
  output logic [7:0]                 x_pc
);

  logic [127:0] mem [NREGS];

  logic [127:0] r_ev_ra, r_ev_rb, r_ev_rc;
  logic [127:0] r_od_ra, r_od_rb, r_od_rt;

  // Later assignments override earlier ones, so scan from lowest to
  // highest priority: array, wb_ev, wb_od, then staging oldest-first.
  function automatic logic [127:0] resolve(input logic [6:0] a);
    logic [127:0] v;
    v = mem[a];
    if (wb_ev_we && wb_ev_addr == a)
      v = wb_ev_data;
    if (wb_od_we && wb_od_addr == a)
      v = wb_od_data;
    for (int i = FW_STAGES - 1; i >= 0; i--) begin
      if (fw_ev_wr[i] && fw_ev_addr[i*7 +: 7] == a)
        v = fw_ev_data[i*128 +: 128];
      if (fw_od_wr[i] && fw_od_addr[i*7 +: 7] == a)
        v = fw_od_data[i*128 +: 128];
    end
    return v;
  endfunction

  always_comb begin
    r_ev_ra = resolve(ev_ra_addr);
    r_ev_rb = resolve(ev_rb_addr);
    r_ev_rc = resolve(ev_rc_addr);
    r_od_ra = resolve(od_ra_addr);
    r_od_rb = resolve(od_rb_addr);
    r_od_rt = resolve(od_rt_addr);
  end

  // Odd write lands last so it wins a same-address collision.
  always_ff @(posedge clk) begin
`ifdef RF_RESET_CLEAR_EN
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else begin
      if (wb_ev_we)
        mem[wb_ev_addr] <= wb_ev_data;
      if (wb_od_we)
        mem[wb_od_addr] <= wb_od_data;
    end
`else
    if (!reset) begin
      if (wb_ev_we)
        mem[wb_ev_addr] <= wb_ev_data;
      if (wb_od_we)
        mem[wb_od_addr] <= wb_od_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_x_op        <= '0;
      ev_x_format    <= '0;
      ev_x_unit      <= '0;
      ev_x_imm       <= '0;
      ev_x_rt_addr   <= '0;
      ev_x_reg_write <= 1'b0;
      od_x_op        <= '0;
      od_x_format    <= '0;
      od_x_unit      <= '0;
      od_x_imm       <= '0;
      od_x_rt_addr   <= '0;
      od_x_reg_write <= 1'b0;
      ev_x_ra        <= '0;
      ev_x_rb        <= '0;
      ev_x_rc        <= '0;
      od_x_ra        <= '0;
      od_x_rb        <= '0;
      od_x_rt_st     <= '0;
      x_pc           <= '0;
    end else if (flush) begin
      ev_x_op        <= '0;
      ev_x_reg_write <= 1'b0;
      od_x_op        <= '0;
      od_x_reg_write <= 1'b0;
    end else if (!stall) begin
      ev_x_op        <= ev_op;
      ev_x_format    <= ev_format;
      ev_x_unit      <= ev_unit;
      ev_x_imm       <= ev_imm;
      ev_x_rt_addr   <= ev_rt_addr;
      ev_x_reg_write <= ev_reg_write;
      od_x_op        <= od_op;
      od_x_format    <= od_format;
      od_x_unit      <= od_unit;
      od_x_imm       <= od_imm;
      od_x_rt_addr   <= od_rt_addr;
      od_x_reg_write <= od_reg_write;
      ev_x_ra        <= r_ev_ra;
      ev_x_rb        <= r_ev_rb;
      ev_x_rc        <= r_ev_rc;
      od_x_ra        <= r_od_ra;
      od_x_rb        <= r_od_rb;
      od_x_rt_st     <= r_od_rt;
      x_pc           <= pc_in;
    end
  end

endmodule

// File: tb/tb_rf_fwd_stage.sv
// Bench for rf_fwd_stage: priority vectors, corner sequences, random vs model.
// Honours RF_RESET_CLEAR_EN for the expected post-reset array contents.
module tb_rf_fwd_stage;
  localparam int FW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, stall, flush;
  logic [10:0] ev_op, od_op;
  logic [2:0] ev_format, od_format;
  logic [1:0] ev_unit, od_unit;
  logic [17:0] ev_imm, od_imm;
  logic [6:0] ev_rt_addr, od_rt_addr;
  logic ev_reg_write, od_reg_write;
  logic [6:0] ev_ra_addr, ev_rb_addr, ev_rc_addr;
  logic [6:0] od_ra_addr, od_rb_addr;
  logic [7:0] pc_in;
  logic [FW*128-1:0] fw_ev_data, fw_od_data;
  logic [FW*7-1:0] fw_ev_addr, fw_od_addr;
  logic [FW-1:0] fw_ev_wr, fw_od_wr;
  logic [127:0] wb_ev_data, wb_od_data;
  logic [6:0] wb_ev_addr, wb_od_addr;
  logic wb_ev_we, wb_od_we;
  logic [10:0] ev_x_op, od_x_op;
  logic [2:0] ev_x_format, od_x_format;
  logic [1:0] ev_x_unit, od_x_unit;
  logic [17:0] ev_x_imm, od_x_imm;
  logic [6:0] ev_x_rt_addr, od_x_rt_addr;
  logic ev_x_reg_write, od_x_reg_write;
  logic [127:0] ev_x_ra, ev_x_rb, ev_x_rc;
  logic [127:0] od_x_ra, od_x_rb, od_x_rt_st;
  logic [7:0] x_pc;

  rf_fwd_stage #(.FW_STAGES(FW), .NREGS(128)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ev_op(ev_op), .od_op(od_op),
    .ev_format(ev_format), .od_format(od_format),
    .ev_unit(ev_unit), .od_unit(od_unit),
    .ev_imm(ev_imm), .od_imm(od_imm),
    .ev_rt_addr(ev_rt_addr), .od_rt_addr(od_rt_addr),
    .ev_reg_write(ev_reg_write), .od_reg_write(od_reg_write),
    .ev_ra_addr(ev_ra_addr), .ev_rb_addr(ev_rb_addr),
    .ev_rc_addr(ev_rc_addr),
    .od_ra_addr(od_ra_addr), .od_rb_addr(od_rb_addr),
    .pc_in(pc_in),
    .fw_ev_data(fw_ev_data), .fw_od_data(fw_od_data),
    .fw_ev_addr(fw_ev_addr), .fw_od_addr(fw_od_addr),
    .fw_ev_wr(fw_ev_wr), .fw_od_wr(fw_od_wr),
    .wb_ev_data(wb_ev_data), .wb_od_data(wb_od_data),
    .wb_ev_addr(wb_ev_addr), .wb_od_addr(wb_od_addr),
    .wb_ev_we(wb_ev_we), .wb_od_we(wb_od_we),
    .ev_x_op(ev_x_op), .ev_x_format(ev_x_format),
    .ev_x_unit(ev_x_unit), .ev_x_imm(ev_x_imm),
    .ev_x_rt_addr(ev_x_rt_addr), .ev_x_reg_write(ev_x_reg_write),
    .od_x_op(od_x_op), .od_x_format(od_x_format),
    .od_x_unit(od_x_unit), .od_x_imm(od_x_imm),
    .od_x_rt_addr(od_x_rt_addr), .od_x_reg_write(od_x_reg_write),
    .ev_x_ra(ev_x_ra), .ev_x_rb(ev_x_rb), .ev_x_rc(ev_x_rc),
    .od_x_ra(od_x_ra), .od_x_rb(od_x_rb), .od_x_rt_st(od_x_rt_st),
    .x_pc(x_pc)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: register contents plus the expected latch.
  typedef struct packed {
    logic [10:0] ev_op, od_op;
    logic [2:0] ev_fmt, od_fmt;
    logic [1:0] ev_unit, od_unit;
    logic [17:0] ev_imm, od_imm;
    logic [6:0] ev_rt, od_rt;
    logic ev_rw, od_rw;
    logic [127:0] ra, rb, rc, ora, orb, ort;
    logic [7:0] pc;
    logic opv;
  } exp_t;

  logic [127:0] mm [128];
  exp_t e;

  function automatic logic [127:0] mres(input logic [6:0] a);
    for (int i = 0; i < FW; i++) begin
      if (fw_od_wr[i] && fw_od_addr[i*7 +: 7] == a)
        return fw_od_data[i*128 +: 128];
      if (fw_ev_wr[i] && fw_ev_addr[i*7 +: 7] == a)
        return fw_ev_data[i*128 +: 128];
    end
    if (wb_od_we && wb_od_addr == a) return wb_od_data;
    if (wb_ev_we && wb_ev_addr == a) return wb_ev_data;
    return mm[a];
  endfunction

  task automatic tick();
    exp_t n;
    n = e;
    if (reset) begin
      n = '0;
      n.opv = 1'b1;
    end else if (flush) begin
      n.ev_op = '0; n.od_op = '0;
      n.ev_rw = 1'b0; n.od_rw = 1'b0;
      n.opv = 1'b0;
    end else if (!stall) begin
      n.ev_op = ev_op; n.od_op = od_op;
      n.ev_fmt = ev_format; n.od_fmt = od_format;
      n.ev_unit = ev_unit; n.od_unit = od_unit;
      n.ev_imm = ev_imm; n.od_imm = od_imm;
      n.ev_rt = ev_rt_addr; n.od_rt = od_rt_addr;
      n.ev_rw = ev_reg_write; n.od_rw = od_reg_write;
      n.ra = mres(ev_ra_addr); n.rb = mres(ev_rb_addr);
      n.rc = mres(ev_rc_addr); n.ora = mres(od_ra_addr);
      n.orb = mres(od_rb_addr); n.ort = mres(od_rt_addr);
      n.pc = pc_in;
      n.opv = 1'b1;
    end
    if (reset) begin
`ifdef RF_RESET_CLEAR_EN
      for (int i = 0; i < 128; i++) mm[i] = '0;
`endif
    end else begin
      if (wb_ev_we) mm[wb_ev_addr] = wb_ev_data;
      if (wb_od_we) mm[wb_od_addr] = wb_od_data;
    end
    @(posedge clk);
    #1;
    e = n;
  endtask

  task automatic check_model();
    chk("m_ev_op", ev_x_op, e.ev_op);
    chk("m_od_op", od_x_op, e.od_op);
    chk("m_ev_rw", ev_x_reg_write, e.ev_rw);
    chk("m_od_rw", od_x_reg_write, e.od_rw);
    if (e.opv) begin
      chk("m_ev_fmt", ev_x_format, e.ev_fmt);
      chk("m_od_fmt", od_x_format, e.od_fmt);
      chk("m_ev_unit", ev_x_unit, e.ev_unit);
      chk("m_od_unit", od_x_unit, e.od_unit);
      chk("m_ev_imm", ev_x_imm, e.ev_imm);
      chk("m_od_imm", od_x_imm, e.od_imm);
      chk("m_ev_rt", ev_x_rt_addr, e.ev_rt);
      chk("m_od_rt", od_x_rt_addr, e.od_rt);
      chk("m_ra", ev_x_ra, e.ra);
      chk("m_rb", ev_x_rb, e.rb);
      chk("m_rc", ev_x_rc, e.rc);
      chk("m_ora", od_x_ra, e.ora);
      chk("m_orb", od_x_rb, e.orb);
      chk("m_ort", od_x_rt_st, e.ort);
      chk("m_pc", x_pc, e.pc);
    end
  endtask

  task automatic clr();
    reset = 0; stall = 0; flush = 0;
    ev_op = 0; od_op = 0; ev_format = 0; od_format = 0;
    ev_unit = 0; od_unit = 0; ev_imm = 0; od_imm = 0;
    ev_rt_addr = 0; od_rt_addr = 0;
    ev_reg_write = 0; od_reg_write = 0;
    ev_ra_addr = 0; ev_rb_addr = 0; ev_rc_addr = 0;
    od_ra_addr = 0; od_rb_addr = 0; pc_in = 0;
    fw_ev_data = '0; fw_od_data = '0;
    fw_ev_addr = '0; fw_od_addr = '0;
    fw_ev_wr = '0; fw_od_wr = '0;
    wb_ev_data = '0; wb_od_data = '0;
    wb_ev_addr = 0; wb_od_addr = 0;
    wb_ev_we = 0; wb_od_we = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    string nm;
    int od_i;
    int ev_i;
    bit wbo;
    bit wbe;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] VX = 128'h1111_0000_0000_0000_0000_0000_0000_000a;
  localparam logic [127:0] VY = 128'h2222_0000_0000_0000_0000_0000_0000_000b;
  localparam logic [127:0] VZ = 128'h3333_0000_0000_0000_0000_0000_0000_000c;
  localparam logic [127:0] VO = 128'h4444_0000_0000_0000_0000_0000_0000_000d;
  localparam logic [127:0] VW = 128'h5555_0000_0000_0000_0000_0000_0000_000e;

  vec_t vt [8];
  logic [10:0] hold_op;
  logic [127:0] hold_ra;

  initial begin
    vt[0] = '{"fwod2_over_all", 2, 4, 1'b0, 1'b1, VX};
    vt[1] = '{"fwev4_after_drop", -1, 4, 1'b0, 1'b1, VY};
    vt[2] = '{"wbev_over_array", -1, -1, 1'b0, 1'b1, VZ};
    vt[3] = '{"wbod_over_wbev", -1, -1, 1'b1, 1'b1, VO};
    vt[4] = '{"array_only", -1, -1, 1'b0, 1'b0, VW};
    vt[5] = '{"tie_idx1_odd", 1, 1, 1'b0, 1'b0, VX};
    vt[6] = '{"low_idx_wins", 3, 1, 1'b0, 1'b0, VY};
    vt[7] = '{"fwod0_over_wbod", 0, 6, 1'b1, 1'b0, VX};

    e = '0;
    for (int i = 0; i < 128; i++) mm[i] = '0;
    clr();
    reset = 1;
    pc_in = 8'h5a; ev_op = 11'h7ff; ev_reg_write = 1;
    tick();
    tick();
    chk("rst_ev_op", ev_x_op, 0);
    chk("rst_ev_rw", ev_x_reg_write, 0);
    chk("rst_od_rw", od_x_reg_write, 0);
    chk("rst_pc", x_pc, 0);
    chk("rst_ra", ev_x_ra, 0);

    clr();
    for (int i = 0; i < 64; i++) begin
      wb_ev_we = 1; wb_ev_addr = 7'(2 * i); wb_ev_data = rnd128();
      wb_od_we = 1; wb_od_addr = 7'(2 * i + 1); wb_od_data = rnd128();
      tick();
    end

    // Forwarding priority table, every source aimed at R9.
    clr();
    wb_ev_we = 1; wb_ev_addr = 9; wb_ev_data = VW;
    tick();
    foreach (vt[k]) begin
      clr();
      for (int i = 0; i < FW; i++) begin
        fw_ev_addr[i*7 +: 7] = 7'd9;
        fw_od_addr[i*7 +: 7] = 7'd9;
        fw_ev_data[i*128 +: 128] = {96'h0, 32'hbad0_0000 + i};
        fw_od_data[i*128 +: 128] = {96'h0, 32'hc0d0_0000 + i};
      end
      if (vt[k].od_i >= 0) begin
        fw_od_wr[vt[k].od_i] = 1'b1;
        fw_od_data[vt[k].od_i*128 +: 128] = VX;
      end
      if (vt[k].ev_i >= 0) begin
        fw_ev_wr[vt[k].ev_i] = 1'b1;
        fw_ev_data[vt[k].ev_i*128 +: 128] = VY;
      end
      wb_ev_we = vt[k].wbe; wb_ev_addr = 9; wb_ev_data = VZ;
      wb_od_we = vt[k].wbo; wb_od_addr = 9; wb_od_data = VO;
      ev_ra_addr = 9; od_rb_addr = 9;
      tick();
      chk({vt[k].nm, "_ev"}, ev_x_ra, vt[k].exp);
      chk({vt[k].nm, "_od"}, od_x_rb, vt[k].exp);
      clr();
      wb_ev_we = 1; wb_ev_addr = 9; wb_ev_data = VW;
      tick();
    end

    // Writeback then read.
    clr();
    wb_ev_we = 1; wb_ev_addr = 5; wb_ev_data = {16{8'ha5}};
    tick();
    clr();
    ev_ra_addr = 5;
    tick();
    chk("wb_then_read", ev_x_ra, {16{8'ha5}});

    // Same-cycle odd writeback bypass over a stale value.
    clr();
    wb_ev_we = 1; wb_ev_addr = 7; wb_ev_data = {4{32'hdead_beef}};
    tick();
    clr();
    wb_od_we = 1; wb_od_addr = 7; wb_od_data = 128'h1234;
    od_rb_addr = 7;
    tick();
    chk("same_cycle_bypass", od_x_rb, 128'h1234);

    // Dual writeback collision on R3.
    clr();
    wb_ev_we = 1; wb_ev_addr = 3; wb_ev_data = 128'he;
    wb_od_we = 1; wb_od_addr = 3; wb_od_data = 128'hf;
    tick();
    clr();
    ev_rb_addr = 3;
    tick();
    chk("dual_wb_odd_wins", ev_x_rb, 128'hf);

    // Stall three cycles, then flush.
    clr();
    ev_op = 11'h123; od_op = 11'h456;
    ev_reg_write = 1; od_reg_write = 1;
    ev_ra_addr = 5;
    tick();
    hold_op = ev_x_op;
    hold_ra = ev_x_ra;
    chk("pre_stall_op", ev_x_op, 11'h123);
    stall = 1; ev_op = 11'h0aa; ev_ra_addr = 3; ev_reg_write = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_op", ev_x_op, 11'h123);
      chk("stall_ra", ev_x_ra, {16{8'ha5}});
      chk("stall_rw", ev_x_reg_write, 1);
    end
    flush = 1;
    ev_reg_write = 1; od_reg_write = 1;
    tick();
    chk("flush_ev_rw", ev_x_reg_write, 0);
    chk("flush_od_rw", od_x_reg_write, 0);
    chk("flush_ev_op", ev_x_op, 0);
    chk("flush_od_op", od_x_op, 0);

    // Reset mid-stream with a write presented in the reset cycle.
    clr();
    wb_ev_we = 1; wb_ev_addr = 2; wb_ev_data = 128'h5;
    tick();
    clr();
    ev_ra_addr = 2; ev_op = 11'h3; od_reg_write = 1; pc_in = 8'h44;
    tick();
    chk("pre_rst_r2", ev_x_ra, 128'h5);
    reset = 1;
    wb_ev_we = 1; wb_ev_addr = 2; wb_ev_data = 128'h77;
    tick();
    chk("mid_rst_ra", ev_x_ra, 0);
    chk("mid_rst_op", ev_x_op, 0);
    chk("mid_rst_od_rw", od_x_reg_write, 0);
    chk("mid_rst_pc", x_pc, 0);
    clr();
    ev_ra_addr = 2;
    tick();
`ifdef RF_RESET_CLEAR_EN
    chk("post_rst_r2", ev_x_ra, 128'h0);
`else
    chk("post_rst_r2", ev_x_ra, 128'h5);
`endif

    // Randomized traffic on a narrow address window.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) < 3);
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 10);
      ev_op = 11'($urandom); od_op = 11'($urandom);
      ev_format = 3'($urandom); od_format = 3'($urandom);
      ev_unit = 2'($urandom); od_unit = 2'($urandom);
      ev_imm = 18'($urandom); od_imm = 18'($urandom);
      ev_rt_addr = 7'($urandom_range(0, 15));
      od_rt_addr = 7'($urandom_range(0, 15));
      ev_reg_write = 1'($urandom); od_reg_write = 1'($urandom);
      ev_ra_addr = 7'($urandom_range(0, 15));
      ev_rb_addr = 7'($urandom_range(0, 15));
      ev_rc_addr = 7'($urandom_range(0, 15));
      od_ra_addr = 7'($urandom_range(0, 15));
      od_rb_addr = 7'($urandom_range(0, 15));
      pc_in = 8'($urandom);
      for (int i = 0; i < FW; i++) begin
        fw_ev_data[i*128 +: 128] = rnd128();
        fw_od_data[i*128 +: 128] = rnd128();
        fw_ev_addr[i*7 +: 7] = 7'($urandom_range(0, 15));
        fw_od_addr[i*7 +: 7] = 7'($urandom_range(0, 15));
        fw_ev_wr[i] = ($urandom_range(0, 99) < 20);
        fw_od_wr[i] = ($urandom_range(0, 99) < 20);
      end
      wb_ev_data = rnd128(); wb_od_data = rnd128();
      wb_ev_addr = 7'($urandom_range(0, 15));
      wb_od_addr = 7'($urandom_range(0, 15));
      wb_ev_we = 1'($urandom); wb_od_we = 1'($urandom);
      tick();
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
